// File: rtl/fir_stream_host_pkg.sv
// Shared defaults and state encoding for the FIR stream host and its bus interface.
package fir_stream_host_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int BUF_DEPTH_DEF  = 64;
  localparam int RES_DEPTH_DEF  = 8;
  localparam int TIMEOUT_DEF    = 1024;

  // One-hot run sequencer states
  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_FETCH    = 5'b00010,
    S_SEND     = 5'b00100,
    S_WAIT_RES = 5'b01000,
    S_DONE     = 5'b10000
  } state_e;

endpackage

// File: rtl/fir_stream_host_if.sv
// Control, FIR handshake and result-stream signals of the FIR stream host.
interface fir_stream_host_if
  import fir_stream_host_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF
);
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int ADDR_W = $clog2(BUF_DEPTH);

  logic                  i_start;
  logic [CNT_W-1:0]      iv_num_samples;
  logic                  i_load_we;
  logic [ADDR_W-1:0]     iv_load_addr;
  logic [DATA_WIDTH-1:0] iv_load_data;
  logic [DATA_WIDTH-1:0] ov_fir_din;
  logic                  o_fir_din_valid;
  logic                  i_fir_ready;
  logic                  o_fir_ready;
  logic [DATA_WIDTH-1:0] iv_fir_dout;
  logic                  i_fir_dout_valid;
  logic [DATA_WIDTH-1:0] ov_res_data;
  logic                  o_res_valid;
  logic                  i_res_ready;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_overflow;
  logic                  o_timeout;

  modport slave (
    input  i_start, iv_num_samples, i_load_we, iv_load_addr, iv_load_data,
           i_fir_ready, iv_fir_dout, i_fir_dout_valid, i_res_ready,
    output ov_fir_din, o_fir_din_valid, o_fir_ready, ov_res_data, o_res_valid,
           o_busy, o_done, o_overflow, o_timeout
  );

  modport master (
    output i_start, iv_num_samples, i_load_we, iv_load_addr, iv_load_data,
           i_fir_ready, iv_fir_dout, i_fir_dout_valid, i_res_ready,
    input  ov_fir_din, o_fir_din_valid, o_fir_ready, ov_res_data, o_res_valid,
           o_busy, o_done, o_overflow, o_timeout
  );

endinterface

// File: rtl/fir_stream_host_result_fifo.sv
// Synchronous result FIFO with registered full/empty flags and a fall-through head.
module fir_stream_host_result_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] iv_push_data,
  output logic                  o_drop,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] ov_head,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic        full_q, full_d, empty_q, empty_d;
  logic        do_push, do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle
  always_comb begin
    do_pop  = i_pop && !empty_q;
    do_push = i_push && (!full_q || do_pop);
    wr_d    = do_push ? wr_q + PONE : wr_q;
    rd_d    = do_pop ? rd_q + PONE : rd_q;
    full_d  = (wr_d[PW] != rd_d[PW]) && (wr_d[PW-1:0] == rd_d[PW-1:0]);
    empty_d = (wr_d == rd_d);
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_q[PW-1:0]] <= iv_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign ov_head = empty_q ? '0 : mem[rd_q[PW-1:0]];
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_drop  = i_push && !do_push;

endmodule

// File: rtl/fir_stream_host.sv
// Replays a loaded sample buffer into the FIR core one sample at a time and
// queues every FIR result into a FIFO drained by a valid/ready stream.
module fir_stream_host
  import fir_stream_host_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter int RES_DEPTH  = RES_DEPTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  fir_stream_host_if.slave bus
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  state_e                state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d, n_q, n_d, n_clip, idx_nxt;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  ovf_q, ovf_d, to_q, to_d;
  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic                  fifo_full, fifo_empty, fifo_drop;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign n_clip  = (bus.iv_num_samples > CW'(BUF_DEPTH)) ? CW'(BUF_DEPTH) : bus.iv_num_samples;
  assign idx_nxt = idx_q + CW'(1);

  // Buffer is only writable between runs so a replay always sees stable data
  always_ff @(posedge i_clk) begin
    if (bus.i_load_we && state_q == S_IDLE) buf_mem[bus.iv_load_addr] <= bus.iv_load_data;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    timer_d = timer_q;
    din_d   = din_q;
    ovf_d   = ovf_q | fifo_drop;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          n_d = n_clip;
          if (n_clip == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            idx_d   = '0;
            ovf_d   = fifo_drop;
            to_d    = 1'b0;
          end
        end
      end
      S_FETCH: begin
        din_d   = buf_mem[idx_q[AW-1:0]];
        state_d = S_SEND;
      end
      S_SEND: begin
        if (bus.i_fir_ready) begin
          state_d = S_WAIT_RES;
          timer_d = '0;
        end
      end
      S_WAIT_RES: begin
        if (bus.i_fir_dout_valid) begin
          idx_d   = idx_nxt;
          state_d = (idx_nxt == n_q) ? S_DONE : S_FETCH;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      timer_q <= '0;
      din_q   <= '0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      timer_q <= timer_d;
      din_q   <= din_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
    end
  end

  // Results are accepted in any state, not only while a sample is outstanding
  fir_stream_host_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RES_DEPTH)
  ) u_res_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (bus.i_fir_dout_valid),
    .iv_push_data (bus.iv_fir_dout),
    .o_drop       (fifo_drop),
    .i_pop        (bus.i_res_ready),
    .ov_head      (fifo_head),
    .o_full       (fifo_full),
    .o_empty      (fifo_empty)
  );

  assign bus.ov_fir_din      = din_q;
  assign bus.o_fir_din_valid = (state_q == S_SEND);
  assign bus.o_fir_ready     = !fifo_full;
  assign bus.ov_res_data     = fifo_head;
  assign bus.o_res_valid     = !fifo_empty;
  assign bus.o_busy          = (state_q != S_IDLE);
  assign bus.o_done          = (state_q == S_DONE);
  assign bus.o_overflow      = ovf_q;
  assign bus.o_timeout       = to_q;

endmodule

// File: tb/tb_fir_stream_host.sv
// Bench for fir_stream_host: echo-FIR model, result collector, run table, corner sequences, random runs.
module tb_fir_stream_host;
  import fir_stream_host_pkg::*;

  localparam int DW      = DATA_WIDTH_DEF;
  localparam int BD      = BUF_DEPTH_DEF;
  localparam int RD      = RES_DEPTH_DEF;
  localparam int TO      = TIMEOUT_DEF;
  localparam int AW      = $clog2(BD);
  localparam int CW      = $clog2(BD + 1);
  localparam int FIR_LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_stream_host_if bus ();
  fir_stream_host dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct { int due; logic [DW-1:0] data; } pend_t;
  typedef struct { int n; bit echo; bit rrdy; int exp_sent; int exp_res; bit exp_ovf; bit exp_to; } row_t;

  pend_t         pend[$];
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] ref_buf [BD];
  row_t          tbl [5];

  int checks = 0, failures = 0, cyc = 0, done_cnt = 0;
  int acc_edge = -1, to_edge = -1, done_edge = -1;
  bit fir_echo = 1'b1, rand_mode = 1'b0;
  bit xfer = 1'b0;
  logic [DW-1:0] xdat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Everything seen here is what the coming rising edge will act on
  always @(negedge clk) begin
    xfer = bus.o_fir_din_valid && bus.i_fir_ready && !rst;
    xdat = bus.ov_fir_din;
    if (xfer) acc_edge = cyc + 1;
    if (bus.o_res_valid && bus.i_res_ready && !rst) got_q.push_back(bus.ov_res_data);
    if (bus.o_done) begin
      done_cnt++;
      done_edge = cyc;
    end
    if (bus.o_timeout && to_edge < 0) to_edge = cyc;
  end

  // FIR model: identity filter answering FIR_LAT cycles after each accepted sample
  always @(posedge clk) begin
    #1;
    if (xfer) begin
      sent_q.push_back(xdat);
      if (fir_echo) pend.push_back('{due: cyc + FIR_LAT - 1, data: xdat});
    end
    bus.i_fir_dout_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.iv_fir_dout      = pend[0].data;
      bus.i_fir_dout_valid = 1'b1;
      void'(pend.pop_front());
    end
    if (rand_mode) begin
      bus.i_fir_ready = ($urandom_range(3) != 0);
      bus.i_res_ready = ($urandom_range(3) != 0);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < BD; i++) begin
      bus.i_load_we    = 1'b1;
      bus.iv_load_addr = AW'(i);
      bus.iv_load_data = ref_buf[i];
      tick(1);
    end
    bus.i_load_we = 1'b0;
  endtask

  task automatic start_run(input int n);
    sent_q.delete();
    got_q.delete();
    done_cnt = 0;
    to_edge  = -1;
    bus.iv_num_samples = CW'(n);
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && done_cnt == 0; c++) tick(1);
    rand_mode = 1'b0;
  endtask

  // Expected stream is always the first exp_n buffer entries in order
  task automatic check_q(input string nm, input int exp_n, input bit use_sent);
    int sz;
    sz = use_sent ? sent_q.size() : got_q.size();
    check({nm, "_count"}, 64'(sz), 64'(exp_n));
    for (int i = 0; i < sz && i < exp_n; i++)
      check({nm, "_data"}, use_sent ? sent_q[i] : got_q[i], ref_buf[i]);
  endtask

  task automatic drain_and_check(input int exp_sent, input int exp_res);
    bus.i_res_ready = 1'b1;
    bus.i_fir_ready = 1'b1;
    tick(RD + 4);
    check_q("sent", exp_sent, 1'b1);
    check_q("result", exp_res, 1'b0);
    check("res_valid_drained", bus.o_res_valid, 1'b0);
    check("done_pulses", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    bus.i_start = 1'b0; bus.iv_num_samples = '0; bus.i_load_we = 1'b0;
    bus.iv_load_addr = '0; bus.iv_load_data = '0; bus.i_fir_ready = 1'b1;
    bus.iv_fir_dout = '0; bus.i_fir_dout_valid = 1'b0; bus.i_res_ready = 1'b1;

    tick(3);
    rst = 1'b0;
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_done", bus.o_done, 1'b0);
    check("rst_din_valid", bus.o_fir_din_valid, 1'b0);
    check("rst_din", bus.ov_fir_din, '0);
    check("rst_res_valid", bus.o_res_valid, 1'b0);
    check("rst_res_data", bus.ov_res_data, '0);
    check("rst_overflow", bus.o_overflow, 1'b0);
    check("rst_timeout", bus.o_timeout, 1'b0);
    check("rst_fir_ready", bus.o_fir_ready, 1'b1);

    for (int i = 0; i < BD; i++) ref_buf[i] = DW'(i + 1);
    load_all();

    tbl[0] = '{4,   1'b1, 1'b1, 4,  4,  1'b0, 1'b0};
    tbl[1] = '{0,   1'b1, 1'b1, 0,  0,  1'b0, 1'b0};
    tbl[2] = '{100, 1'b1, 1'b1, 64, 64, 1'b0, 1'b0};
    tbl[3] = '{10,  1'b1, 1'b0, 10, 8,  1'b1, 1'b0};
    tbl[4] = '{1,   1'b0, 1'b1, 1,  0,  1'b0, 1'b1};
    for (int r = 0; r < 5; r++) begin
      fir_echo        = tbl[r].echo;
      bus.i_res_ready = tbl[r].rrdy;
      bus.i_fir_ready = 1'b1;
      start_run(tbl[r].n);
      wait_done(8000);
      check("run_done", 64'(done_cnt), 64'd1);
      check("busy_after_done", bus.o_busy, 1'b0);
      check("overflow", bus.o_overflow, tbl[r].exp_ovf);
      check("timeout", bus.o_timeout, tbl[r].exp_to);
      check("fifo_full_at_done", !bus.o_fir_ready, tbl[r].exp_ovf);
      drain_and_check(tbl[r].exp_sent, tbl[r].exp_res);
    end
    check("timeout_latency", 64'(to_edge - acc_edge), 64'(TO));
    check("timeout_done_same_edge", 64'(done_edge), 64'(to_edge));
    fir_echo = 1'b1;

    // n == 0 finishes one cycle after start with no sample offered
    start_run(0);
    check("n0_done", bus.o_done, 1'b1);
    check("n0_din_valid", bus.o_fir_din_valid, 1'b0);
    tick(1);
    check("n0_done_drop", bus.o_done, 1'b0);
    check("n0_idle", bus.o_busy, 1'b0);

    // Latency, backpressure hold and buffer write protection while busy
    bus.i_fir_ready = 1'b0;
    start_run(3);
    check("lat_fetch_valid", bus.o_fir_din_valid, 1'b0);
    check("lat_busy", bus.o_busy, 1'b1);
    tick(1);
    check("lat_send_valid", bus.o_fir_din_valid, 1'b1);
    check("lat_send_din", bus.ov_fir_din, ref_buf[0]);
    bus.i_load_we = 1'b1; bus.iv_load_addr = AW'(1); bus.iv_load_data = DW'(24'hABCDE);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      bus.i_load_we = 1'b0;
      check("bp_valid_held", bus.o_fir_din_valid, 1'b1);
      check("bp_din_stable", bus.ov_fir_din, ref_buf[0]);
    end
    bus.i_fir_ready = 1'b1;
    wait_done(2000);
    check("bp_run_done", 64'(done_cnt), 64'd1);
    drain_and_check(3, 3);

    // Result strobe while idle is still queued; reset mid-SEND flushes everything
    bus.i_res_ready = 1'b0;
    got_q.delete();
    pend.push_back('{due: 0, data: DW'(24'h5A5A5A)});
    tick(2);
    check("idle_push_valid", bus.o_res_valid, 1'b1);
    check("idle_push_data", bus.ov_res_data, DW'(24'h5A5A5A));
    check("idle_push_busy", bus.o_busy, 1'b0);
    bus.i_fir_ready = 1'b0;
    start_run(4);
    tick(2);
    check("pre_rst_send", bus.o_fir_din_valid, 1'b1);
    rst = 1'b1;
    tick(2);
    check("mid_rst_busy", bus.o_busy, 1'b0);
    check("mid_rst_din_valid", bus.o_fir_din_valid, 1'b0);
    check("mid_rst_din", bus.ov_fir_din, '0);
    check("mid_rst_res_valid", bus.o_res_valid, 1'b0);
    check("mid_rst_res_data", bus.ov_res_data, '0);
    check("mid_rst_done", bus.o_done, 1'b0);
    rst = 1'b0;
    pend.delete();
    bus.i_fir_ready = 1'b1;
    bus.i_res_ready = 1'b1;
    tick(4);
    check("post_rst_no_done", 64'(done_cnt), 64'd0);
    check("post_rst_idle", bus.o_busy, 1'b0);

    // Random buffer contents, lengths and handshake stalls
    for (int r = 0; r < 6; r++) begin
      int n, nexp;
      for (int i = 0; i < BD; i++) ref_buf[i] = DW'($urandom);
      load_all();
      n    = $urandom_range(100);
      nexp = (n > BD) ? BD : n;
      rand_mode = 1'b1;
      start_run(n);
      wait_done(8000);
      check("rnd_done", 64'(done_cnt), 64'd1);
      check("rnd_overflow", bus.o_overflow, 1'b0);
      check("rnd_timeout", bus.o_timeout, 1'b0);
      drain_and_check(nexp, nexp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
